// File: rtl/pipe_stall_ctrl.sv
// Purpose : central stall/flush controller for the 5-stage pipeline; resolves
//           memory busy, branch redirect and load-use stall into per-stage controls.
// Latency : pipeline controls are combinational (0 cycles); state/counters/timeout
//           update on the rising clock edge.
// Backpr. : i_mem_busy freezes every stage; a branch seen while frozen is held
//           and applied exactly once on the first non-busy cycle.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_pc_write_req         hazard unit PCWrite (0 = load-use stall)
//   i_if_id_write_req      hazard unit IF/ID write (0 = stall)
//   i_nop_lw_n             hazard unit NOP_LW (0 = bubble in ID/EX)
//   i_branch_taken         EX-stage taken branch/jump pulse
//   i_mem_busy             data memory not ready
//   i_cnt_clear            clear counters and timeout flag
//   o_pc_en .. o_mem_wb_bubble  per-stage enables and flush/bubble controls
//   o_mem_timeout          sticky over-long memory wait flag
//   o_stall_cnt            saturating count of cycles with PC held
//   o_flush_cnt            saturating count of flush cycles
module pipe_stall_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pc_write_req,
  input  logic             i_if_id_write_req,
  input  logic             i_nop_lw_n,
  input  logic             i_branch_taken,
  input  logic             i_mem_busy,
  input  logic             i_cnt_clear,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_bubble,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_bubble,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_FLUSH_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_timeout;
  logic             w_lu_stall;
  logic             w_flush;

  // Any single hazard-unit request is treated as a full load-use stall.
  assign w_lu_stall = ~i_pc_write_req | ~i_if_id_write_req | ~i_nop_lw_n;

  always_comb begin
    o_pc_en         = 1'b1;
    o_if_id_en      = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_en      = 1'b1;
    o_id_ex_bubble  = 1'b0;
    o_ex_mem_en     = 1'b1;
    o_mem_wb_bubble = 1'b0;
    w_flush         = 1'b0;
    w_state_nxt     = ST_RUN;

    if (i_rst) begin
      o_pc_en         = 1'b0;
      o_if_id_en      = 1'b0;
      o_if_id_flush   = 1'b1;
      o_id_ex_en      = 1'b0;
      o_id_ex_bubble  = 1'b1;
      o_ex_mem_en     = 1'b0;
      o_mem_wb_bubble = 1'b1;
    end else if (i_mem_busy) begin
      // Freeze: only MEM/WB gets a bubble so WB does not retire twice.
      o_pc_en         = 1'b0;
      o_if_id_en      = 1'b0;
      o_id_ex_en      = 1'b0;
      o_ex_mem_en     = 1'b0;
      o_mem_wb_bubble = 1'b1;
      if (i_branch_taken || r_state == ST_FLUSH_PEND) begin
        w_state_nxt = ST_FLUSH_PEND;
      end else begin
        w_state_nxt = ST_MEM_WAIT;
      end
    end else if (i_branch_taken || r_state == ST_FLUSH_PEND) begin
      // Flush wins over load-use: the stalled instruction is on the wrong path.
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
      w_flush        = 1'b1;
    end else if (w_lu_stall) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (i_cnt_clear) begin
        r_stall_cnt   <= '0;
        r_flush_cnt   <= '0;
        r_wait_cnt    <= '0;
        r_mem_timeout <= 1'b0;
      end else begin
        if (!o_pc_en && r_stall_cnt != CNT_MAX) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
        if (w_flush && r_flush_cnt != CNT_MAX) begin
          r_flush_cnt <= r_flush_cnt + 1'b1;
        end
        if (i_mem_busy) begin
          if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
          // Set on the same edge the wait count reaches the limit.
          if (r_wait_cnt >= WAIT_LIMIT - 1'b1) begin
            r_mem_timeout <= 1'b1;
          end
        end else begin
          r_wait_cnt <= '0;
        end
      end
    end
  end

  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Purpose : exercises pipe_stall_ctrl (CNT_W=4, MAX_WAIT=3) with directed
//           sequences followed by random traffic against a behavioural model.
// Ports   : none (top-level bench).
module tb_pipe_stall_ctrl;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 3;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             pc_write_req;
  logic             if_id_write_req;
  logic             nop_lw_n;
  logic             branch_taken;
  logic             mem_busy;
  logic             cnt_clear;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             ex_mem_en;
  logic             mem_wb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_pc_write_req    (pc_write_req),
    .i_if_id_write_req (if_id_write_req),
    .i_nop_lw_n        (nop_lw_n),
    .i_branch_taken    (branch_taken),
    .i_mem_busy        (mem_busy),
    .i_cnt_clear       (cnt_clear),
    .o_pc_en           (pc_en),
    .o_if_id_en        (if_id_en),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_en        (id_ex_en),
    .o_id_ex_bubble    (id_ex_bubble),
    .o_ex_mem_en       (ex_mem_en),
    .o_mem_wb_bubble   (mem_wb_bubble),
    .o_mem_timeout     (mem_timeout),
    .o_stall_cnt       (stall_cnt),
    .o_flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model state: a "flush owed" flag instead of a state machine.
  bit m_valid   = 0;
  bit m_pending = 0;
  int m_stall   = 0;
  int m_flush   = 0;
  int m_wait    = 0;
  bit m_tmo     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Controls packed as {pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}.
  task automatic step(input bit r, input bit pcw, input bit ifw, input bit nop,
                      input bit br, input bit busy, input bit clr);
    logic [6:0] exp_ctl;
    bit lu;
    bit stalled;
    bit flushed;
    @(negedge clk);
    if (m_valid) begin
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
    end
    rst = r; pc_write_req = pcw; if_id_write_req = ifw; nop_lw_n = nop;
    branch_taken = br; mem_busy = busy; cnt_clear = clr;
    #1;
    lu = !pcw || !ifw || !nop;
    stalled = 0;
    flushed = 0;
    if (r)                   exp_ctl = 7'b0010101;
    else if (busy)           begin exp_ctl = 7'b0000001; stalled = 1; end
    else if (br || m_pending) begin exp_ctl = 7'b1111110; flushed = 1; end
    else if (lu)             begin exp_ctl = 7'b0001110; stalled = 1; end
    else                     exp_ctl = 7'b1101010;
    chk("controls", 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                         ex_mem_en, mem_wb_bubble}), 32'(exp_ctl));
    // Advance the model to what the next edge should produce.
    if (r) begin
      m_valid = 1; m_pending = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_tmo = 0;
    end else begin
      if (busy) m_pending = m_pending || br;
      else      m_pending = 0;
      if (clr) begin
        m_stall = 0; m_flush = 0; m_wait = 0; m_tmo = 0;
      end else begin
        if (stalled && m_stall < CNT_SAT) m_stall++;
        if (flushed && m_flush < CNT_SAT) m_flush++;
        if (busy) begin
          if (m_wait < CNT_SAT) m_wait++;
          if (m_wait >= MAX_WAIT) m_tmo = 1;
        end else begin
          m_wait = 0;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 1, 0, 0, 0);
  endtask

  initial begin
    rst = 1; pc_write_req = 1; if_id_write_req = 1; nop_lw_n = 1;
    branch_taken = 0; mem_busy = 0; cnt_clear = 0;

    // Reset held three cycles, then normal run.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 0, 0);
    idle(2);

    // Single load-use stall.
    step(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("stall_after_lu", 32'(stall_cnt), 32'd1);

    // Branch and load-use together: flush only.
    step(1, 1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(1);
    chk("flush_br_lu", 32'(flush_cnt), 32'd1);
    chk("stall_br_lu", 32'(stall_cnt), 32'd0);

    // Four busy cycles with a branch on the second, then one flush.
    step(1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 1, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0, 1, 0);
    step(0, 1, 1, 1, 0, 1, 0);
    idle(2);
    chk("flush_after_wait", 32'(flush_cnt), 32'd1);
    chk("stall_after_wait", 32'(stall_cnt), 32'd4);

    // Five busy cycles trip the timeout; cnt_clear drops it.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, 1, 0);
    idle(2);
    chk("timeout_sticky", 32'(mem_timeout), 32'd1);
    step(0, 1, 1, 1, 0, 0, 1);
    idle(1);
    chk("timeout_cleared", 32'(mem_timeout), 32'd0);

    // Twenty load-use cycles saturate the stall counter.
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 0, 0);
    idle(1);
    chk("stall_sat", 32'(stall_cnt), 32'(CNT_SAT));

    // Reset while a flush is pending discards it.
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 1, 0, 0, 0);
    idle(3);
    chk("no_flush_after_rst", 32'(flush_cnt), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, busy, clr;
      r    = ($urandom_range(99) == 0);
      busy = ($urandom_range(99) < 35);
      clr  = !busy && ($urandom_range(99) < 3);
      step(r, ($urandom_range(99) >= 12), ($urandom_range(99) >= 12),
           ($urandom_range(99) >= 12), ($urandom_range(99) < 15), busy, clr);
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central pipeline stall/flush controller for the 5-stage MIPS pipeline. It consumes the load-use stall request from the hazard detection unit, the branch-taken redirect from EX and the busy flag of the multi-cycle data memory. It resolves them by priority into per-stage enables and bubble/flush controls. It holds a pending branch flush across memory wait states, flags over-long memory waits and keeps saturating performance counters.

## Interface
- CNT_W, 16, width of performance counters
- MAX_WAIT, 255, consecutive mem_busy cycles before mem_timeout sets (1..2^CNT_W-1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc_write_req  in  1  hazard unit PCWrite; 0 = load-use stall requested
- if_id_write_req  in  1  hazard unit if_id_Write; 0 = stall
- nop_lw_n  in  1  hazard unit NOP_LW; 0 = insert bubble in ID/EX
- branch_taken  in  1  EX-stage branch/jump resolved taken (1-cycle pulse)
- mem_busy  in  1  data memory not ready; MEM stage must hold
- cnt_clear  in  1  clear all counters and mem_timeout
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_en  out  1  ID/EX register enable
- id_ex_bubble  out  1  ID/EX loads all-zero control
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_bubble  out  1  MEM/WB loads all-zero control
- mem_timeout  out  1  sticky: mem_busy held MAX_WAIT cycles
- stall_cnt  out  CNT_W  cycles with pc_en=0 (post-reset)
- flush_cnt  out  CNT_W  flushes applied

## Operation
- lu_stall = ~pc_write_req | ~if_id_write_req | ~nop_lw_n.
- States: RUN, MEM_WAIT, FLUSH_PEND.
- Priority (highest first): rst, mem_busy, pending/new flush, lu_stall, normal.
- Freeze (mem_busy=1, any state): pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, flush/bubble to IF/ID, ID/EX = 0. Next state MEM_WAIT, or FLUSH_PEND if branch_taken=1 now or already in FLUSH_PEND.
- Flush (mem_busy=0 and (branch_taken=1 or state FLUSH_PEND)): pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1, mem_wb_bubble=0; lu_stall ignored; flush_cnt++; next RUN.
- Load-use (mem_busy=0, no flush, lu_stall=1): pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1; next RUN.
- Normal: all enables 1, all flush/bubble 0; next RUN.
- MEM_WAIT with mem_busy=0 and no branch: behaves as RUN this cycle (normal or load-use); next RUN.
- wait_cnt (internal, CNT_W): increments each cycle mem_busy=1, clears when mem_busy=0; when it reaches MAX_WAIT set mem_timeout (sticky until rst or cnt_clear). Saturates.
- stall_cnt increments on every cycle pc_en=0 outside reset; flush_cnt per flush cycle; both saturate at 2^CNT_W-1, never wrap.
- cnt_clear: counters/mem_timeout go to 0 next edge; increment in that cycle is dropped; cnt_clear has no effect on pipeline controls or state.

## Timing
- All pipeline control outputs are combinational from current state and inputs (0-cycle latency); state, counters, mem_timeout update on rising clk.
- During rst=1: pc_en=if_id_en=id_ex_en=ex_mem_en=0, if_id_flush=id_ex_bubble=mem_wb_bubble=1; next edge: state RUN, counters 0, mem_timeout 0, wait_cnt 0. Counters do not count reset cycles.
- Reset mid-MEM_WAIT/FLUSH_PEND discards the pending flush.
- Pending flush applies in the first cycle mem_busy=0, exactly once.
- branch_taken and lu_stall same cycle: flush only, no stall (stall_cnt unchanged).
- branch_taken while already FLUSH_PEND: single flush, flush_cnt +1 only.
- Hazard inputs disagreeing (e.g., only nop_lw_n=0): treated as full load-use stall.

## Test plan
- Reset: hold rst 3 cycles -> controls at reset values, counters 0; release -> all enables 1, bubbles 0 in RUN.
- Load-use: pc_write_req=if_id_write_req=nop_lw_n=0 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_bubble=1 that cycle; stall_cnt=1.
- Branch + load-use same cycle -> if_id_flush=1, id_ex_bubble=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- mem_busy 4 cycles, branch_taken pulse on 2nd -> 4 frozen cycles (mem_wb_bubble=1), then one flush cycle, then normal; flush_cnt=1, stall_cnt=4.
- MAX_WAIT=3, mem_busy 5 cycles -> mem_timeout rises after 3rd busy edge, stays 1 after busy drops; cnt_clear pulse -> 0 next edge.
- CNT_W=4, 20 load-use cycles -> stall_cnt saturates at 15; reset during FLUSH_PEND -> no flush after release.
